// File: rtl/eth_frame_log_packer.sv
// Packs a control record plus its extracted frame bytes into a log message:
// three header beats followed by the frame data, on a registered AXI-Stream output.
module eth_frame_log_packer #(
    parameter logic [15:0] C_MSG_ID      = 16'h0101,
    parameter int unsigned C_NUM_SCRIPTS = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         srst,
    input  logic         enable,
    input  logic [119:0] s_axis_ctl_tdata,
    input  logic         s_axis_ctl_tvalid,
    output logic         s_axis_ctl_tready,
    input  logic [63:0]  s_axis_frame_tdata,
    input  logic         s_axis_frame_tvalid,
    output logic         s_axis_frame_tready,
    output logic [63:0]  m_axis_tdata,
    output logic [7:0]   m_axis_tkeep,
    output logic         m_axis_tlast,
    output logic         m_axis_tvalid,
    input  logic         m_axis_tready,
    output logic [31:0]  msg_count,
    output logic [31:0]  drop_count
);

    localparam int unsigned BL_W       = 17;
    localparam logic [7:0]  MATCH_MASK = 8'((16'd1 << C_NUM_SCRIPTS) - 16'd1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_HDR2,
        ST_DATA,
        ST_DROP
    } state_t;

    state_t          state;
    logic [BL_W-1:0] beats_left;
    logic [31:0]     number_q;
    logic [15:0]     len_q;
    logic [15:0]     size_q;
    logic [63:0]     ts_q;
    logic [7:0]      match_q;

    logic            load_ok;
    logic            ctl_fire;
    logic            frame_fire;
    logic            last_fire;
    logic [7:0]      ctl_match;
    logic [15:0]     ctl_size;
    logic [31:0]     ctl_number;
    logic [63:0]     ctl_ts;
    logic [BL_W-1:0] ctl_beats;
    logic [7:0]      last_keep;
    logic            final_beat;

    assign ctl_match  = s_axis_ctl_tdata[119:112];
    assign ctl_size   = s_axis_ctl_tdata[111:96];
    assign ctl_number = s_axis_ctl_tdata[95:64];
    assign ctl_ts     = s_axis_ctl_tdata[63:0];
    assign ctl_beats  = BL_W'((BL_W'(ctl_size) + BL_W'(7)) >> 3);

    assign load_ok           = ~m_axis_tvalid | m_axis_tready;
    assign s_axis_ctl_tready = (state == ST_IDLE);
    assign ctl_fire          = s_axis_ctl_tvalid & s_axis_ctl_tready;
    assign frame_fire        = s_axis_frame_tvalid & s_axis_frame_tready;
    assign last_fire         = m_axis_tvalid & m_axis_tready & m_axis_tlast;
    assign final_beat        = (beats_left == BL_W'(1));
    assign last_keep         = (size_q[2:0] == 3'd0) ? 8'hFF
                             : 8'((9'd1 << size_q[2:0]) - 9'd1);

    // Frame input is only open while data is being forwarded or drained
    always_comb begin
        s_axis_frame_tready = 1'b0;
        case (state)
            ST_DATA: s_axis_frame_tready = load_ok;
            ST_DROP: s_axis_frame_tready = 1'b1;
            default: s_axis_frame_tready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            beats_left    <= '0;
            number_q      <= '0;
            len_q         <= '0;
            size_q        <= '0;
            ts_q          <= '0;
            match_q       <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
        end else begin
            // A completed handshake empties the stage; a load below refills it
            if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (ctl_fire) begin
                        beats_left <= ctl_beats;
                        number_q   <= ctl_number;
                        len_q      <= 16'(ctl_size + 16'd24);
                        size_q     <= ctl_size;
                        ts_q       <= ctl_ts;
                        match_q    <= ctl_match & MATCH_MASK;
                        if (enable) begin
                            state <= ST_HDR0;
                        end else if (ctl_beats != '0) begin
                            state <= ST_DROP;
                        end
                    end
                end
                ST_HDR0: begin
                    if (load_ok) begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= {number_q, len_q, C_MSG_ID};
                        m_axis_tkeep  <= 8'hFF;
                        m_axis_tlast  <= 1'b0;
                        state         <= ST_HDR1;
                    end
                end
                ST_HDR1: begin
                    if (load_ok) begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= ts_q;
                        m_axis_tkeep  <= 8'hFF;
                        m_axis_tlast  <= 1'b0;
                        state         <= ST_HDR2;
                    end
                end
                ST_HDR2: begin
                    if (load_ok) begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= {40'd0, match_q, size_q};
                        m_axis_tkeep  <= 8'hFF;
                        m_axis_tlast  <= (beats_left == '0);
                        state         <= (beats_left == '0) ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (frame_fire) begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= s_axis_frame_tdata;
                        m_axis_tkeep  <= final_beat ? last_keep : 8'hFF;
                        m_axis_tlast  <= final_beat;
                        beats_left    <= beats_left - BL_W'(1);
                        if (final_beat) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_DROP: begin
                    if (frame_fire) begin
                        beats_left <= beats_left - BL_W'(1);
                        if (final_beat) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Statistics; srst wins over a same-cycle increment
    always_ff @(posedge clk) begin
        if (!rst_n || srst) begin
            msg_count  <= '0;
            drop_count <= '0;
        end else begin
            if (last_fire) begin
                msg_count <= msg_count + 32'd1;
            end
            if (ctl_fire && !enable) begin
                drop_count <= drop_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_eth_frame_log_packer.sv
// Directed bench for eth_frame_log_packer: vector table of whole messages plus
// hand-written back-to-back, srst-collision and mid-message reset sequences.
module tb_eth_frame_log_packer;

    localparam logic [63:0] FRAME_BASE = 64'hA5A5_0000_0000_0000;

    logic         clk;
    logic         rst_n;
    logic         srst;
    logic         enable;
    logic [119:0] s_axis_ctl_tdata;
    logic         s_axis_ctl_tvalid;
    logic         s_axis_ctl_tready;
    logic [63:0]  s_axis_frame_tdata;
    logic         s_axis_frame_tvalid;
    logic         s_axis_frame_tready;
    logic [63:0]  m_axis_tdata;
    logic [7:0]   m_axis_tkeep;
    logic         m_axis_tlast;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic [31:0]  msg_count;
    logic [31:0]  drop_count;

    eth_frame_log_packer dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .srst                (srst),
        .enable              (enable),
        .s_axis_ctl_tdata    (s_axis_ctl_tdata),
        .s_axis_ctl_tvalid   (s_axis_ctl_tvalid),
        .s_axis_ctl_tready   (s_axis_ctl_tready),
        .s_axis_frame_tdata  (s_axis_frame_tdata),
        .s_axis_frame_tvalid (s_axis_frame_tvalid),
        .s_axis_frame_tready (s_axis_frame_tready),
        .m_axis_tdata        (m_axis_tdata),
        .m_axis_tkeep        (m_axis_tkeep),
        .m_axis_tlast        (m_axis_tlast),
        .m_axis_tvalid       (m_axis_tvalid),
        .m_axis_tready       (m_axis_tready),
        .msg_count           (msg_count),
        .drop_count          (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        int unsigned cyc;
    } beat_t;

    typedef struct {
        logic        en;
        logic [15:0] size;
        logic [31:0] number;
        logic [63:0] ts;
        logic [7:0]  match;
        int unsigned mode;
        int unsigned n_beats;
        int unsigned n_frames;
        logic [7:0]  last_keep;
        logic [63:0] hdr0;
        logic [63:0] hdr2;
    } vec_t;

    int unsigned checks    = 0;
    int unsigned failures  = 0;
    int unsigned frame_cnt = 0;
    int unsigned cyc       = 0;
    int unsigned tr_mode   = 0;
    int unsigned exp_msg   = 0;
    int unsigned exp_drop  = 0;
    logic        tog       = 1'b0;
    beat_t       out_q[$];
    vec_t        vecs[7];

    // tr_mode: 0 always ready, 1 toggling, 2 stalled
    assign m_axis_tready      = (tr_mode == 0) || ((tr_mode == 1) && tog);
    assign s_axis_frame_tdata = FRAME_BASE + 64'(frame_cnt);

    always @(negedge clk) tog <= ~tog;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (s_axis_frame_tvalid && s_axis_frame_tready) frame_cnt <= frame_cnt + 1;
        if (rst_n && m_axis_tvalid && m_axis_tready)
            out_q.push_back('{m_axis_tdata, m_axis_tkeep, m_axis_tlast, cyc});
    end

    // Stalled beats must be presented unchanged on the following cycle
    logic        hold_pend = 1'b0;
    logic [72:0] hold_val  = '0;
    always @(posedge clk) begin
        hold_pend <= rst_n && m_axis_tvalid && !m_axis_tready;
        hold_val  <= {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
    end
    always @(negedge clk) begin
        if (hold_pend && rst_n) begin
            checks = checks + 1;
            if (!m_axis_tvalid || ({m_axis_tlast, m_axis_tkeep, m_axis_tdata} != hold_val)) begin
                failures = failures + 1;
                $display("FAIL hold_stable: got valid=%0b %h expected valid=1 %h",
                         m_axis_tvalid, {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, hold_val);
            end
        end
    end

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Presents a record and returns at the negedge after it is accepted; tvalid stays high
    task automatic send_ctl(input logic en, input logic [15:0] size, input logic [31:0] number,
                            input logic [63:0] ts, input logic [7:0] match);
        logic acc;
        acc = 1'b0;
        enable            = en;
        s_axis_ctl_tdata  = {match, size, number, ts};
        s_axis_ctl_tvalid = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            if (s_axis_ctl_tready) acc = 1'b1;
            @(negedge clk);
        end
        check("ctl_accept", 80'(acc), 80'(1));
    endtask

    task automatic wait_done(input string name, input int unsigned n_beats,
                             input int unsigned f0, input int unsigned n_frames);
        for (int i = 0; i < 20000; i++) begin
            if (out_q.size() >= n_beats && (frame_cnt - f0) >= n_frames) break;
            @(negedge clk);
        end
        tick(6);
        check({name, "_beats"}, 80'(out_q.size()), 80'(n_beats));
        check({name, "_frames"}, 80'(frame_cnt - f0), 80'(n_frames));
    endtask

    initial begin
        int unsigned f0;
        int unsigned n;
        logic [63:0] ed;
        logic [7:0]  ek;
        logic        el;
        logic        seen;

        //             en  size      number         ts                      match mode beats frames keep   hdr0                    hdr2
        vecs[0] = '{1'b1, 16'd13,    32'd5,         64'h1122,               8'h03, 0, 5,    2,    8'h1F, 64'h0000_0005_0025_0101, 64'h0000_0000_0003_000D};
        vecs[1] = '{1'b1, 16'd0,     32'd7,         64'hAA,                 8'hF0, 0, 3,    0,    8'hFF, 64'h0000_0007_0018_0101, 64'h0000_0000_0000_0000};
        vecs[2] = '{1'b1, 16'd16,    32'hDEADBEEF,  64'h0123_4567_89AB_CDEF, 8'h01, 1, 5,    2,    8'hFF, 64'hDEAD_BEEF_0028_0101, 64'h0000_0000_0001_0010};
        vecs[3] = '{1'b0, 16'd20,    32'd9,         64'h0,                  8'h00, 0, 0,    3,    8'hFF, 64'h0,                  64'h0};
        vecs[4] = '{1'b1, 16'd1,     32'hFFFF_FFFF, 64'h0,                  8'hFF, 0, 4,    1,    8'h01, 64'hFFFF_FFFF_0019_0101, 64'h0000_0000_000F_0001};
        vecs[5] = '{1'b0, 16'd0,     32'd3,         64'h0,                  8'h00, 0, 0,    0,    8'hFF, 64'h0,                  64'h0};
        vecs[6] = '{1'b1, 16'hFFFF,  32'd1,         64'hFFFF_FFFF_FFFF_FFFF, 8'h08, 0, 8195, 8192, 8'h7F, 64'h0000_0001_0017_0101, 64'h0000_0000_0008_FFFF};

        rst_n               = 1'b0;
        srst                = 1'b0;
        enable              = 1'b1;
        s_axis_ctl_tdata    = '0;
        s_axis_ctl_tvalid   = 1'b0;
        s_axis_frame_tvalid = 1'b1;
        tick(3);
        check("rst_tvalid", 80'(m_axis_tvalid), 80'(0));
        check("rst_tdata", 80'(m_axis_tdata), 80'(0));
        check("rst_tkeep_tlast", 80'({m_axis_tkeep, m_axis_tlast}), 80'(0));
        check("rst_counts", 80'({msg_count, drop_count}), 80'(0));
        rst_n = 1'b1;
        tick(2);
        check("idle_ctl_tready", 80'(s_axis_ctl_tready), 80'(1));
        check("idle_frame_tready", 80'(s_axis_frame_tready), 80'(0));

        for (int v = 0; v < 7; v++) begin
            out_q.delete();
            f0      = frame_cnt;
            tr_mode = vecs[v].mode;
            send_ctl(vecs[v].en, vecs[v].size, vecs[v].number, vecs[v].ts, vecs[v].match);
            s_axis_ctl_tvalid = 1'b0;
            wait_done($sformatf("v%0d", v), vecs[v].n_beats, f0, vecs[v].n_frames);
            tr_mode = 0;
            n = vecs[v].n_beats;
            for (int i = 0; i < int'(n); i++) begin
                if (i == 0)      ed = vecs[v].hdr0;
                else if (i == 1) ed = vecs[v].ts;
                else if (i == 2) ed = vecs[v].hdr2;
                else             ed = FRAME_BASE + 64'(f0) + 64'(i - 3);
                el = (i == int'(n) - 1);
                ek = (i >= 3 && el) ? vecs[v].last_keep : 8'hFF;
                if (i < out_q.size())
                    check($sformatf("v%0d_beat%0d", v, i),
                          {7'd0, out_q[i].last, out_q[i].keep, out_q[i].data}, {7'd0, el, ek, ed});
            end
            if (vecs[v].en) exp_msg = exp_msg + 1;
            else            exp_drop = exp_drop + 1;
            check($sformatf("v%0d_msg_count", v), 80'(msg_count), 80'(exp_msg));
            check($sformatf("v%0d_drop_count", v), 80'(drop_count), 80'(exp_drop));
        end

        // Back-to-back records; enable drops while the second message is in flight
        out_q.delete();
        f0 = frame_cnt;
        send_ctl(1'b1, 16'd8, 32'h11, 64'h22, 8'h01);
        send_ctl(1'b1, 16'd9, 32'h33, 64'h44, 8'h02);
        s_axis_ctl_tvalid = 1'b0;
        enable = 1'b0;
        wait_done("b2b", 9, f0, 3);
        enable = 1'b1;
        exp_msg = exp_msg + 2;
        if (out_q.size() == 9) begin
            check("b2b_first_last", 80'({out_q[3].last, out_q[3].keep}), 80'({1'b1, 8'hFF}));
            check("b2b_hdr0", 80'(out_q[4].data), 80'(64'h0000_0033_0021_0101));
            check("b2b_gap_le2", 80'((out_q[4].cyc - out_q[3].cyc) <= 2), 80'(1));
            check("b2b_second_last", 80'({out_q[8].last, out_q[8].keep, out_q[8].data}),
                  {7'd0, 1'b1, 8'h01, FRAME_BASE + 64'(f0) + 64'd2});
        end
        check("b2b_msg_count", 80'(msg_count), 80'(exp_msg));

        // srst coincides with the handshake of a final tlast beat
        out_q.delete();
        send_ctl(1'b1, 16'd0, 32'h77, 64'h1, 8'h00);
        s_axis_ctl_tvalid = 1'b0;
        for (int i = 0; i < 50 && out_q.size() < 2; i++) @(negedge clk);
        tr_mode = 2;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (m_axis_tvalid && m_axis_tlast) seen = 1'b1;
            else @(negedge clk);
        end
        check("srst_tlast_pending", 80'(seen), 80'(1));
        srst    = 1'b1;
        tr_mode = 0;
        @(negedge clk);
        srst = 1'b0;
        tick(2);
        check("srst_beats", 80'(out_q.size()), 80'(3));
        check("srst_counts", 80'({msg_count, drop_count}), 80'(0));

        // Reset in the middle of a data phase abandons the message
        out_q.delete();
        send_ctl(1'b1, 16'd64, 32'h99, 64'h5, 8'h00);
        s_axis_ctl_tvalid = 1'b0;
        tick(4);
        rst_n = 1'b0;
        tick(2);
        check("mrst_tvalid", 80'(m_axis_tvalid), 80'(0));
        check("mrst_out", 80'({m_axis_tlast, m_axis_tkeep, m_axis_tdata}), 80'(0));
        n = out_q.size();
        rst_n = 1'b1;
        tick(10);
        check("mrst_no_more_beats", 80'(out_q.size()), 80'(n));
        check("mrst_idle", 80'({s_axis_ctl_tready, s_axis_frame_tready}), 80'(2'b10));
        check("mrst_counts", 80'({msg_count, drop_count}), 80'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
